// File: rtl/mem_rst_pkg.sv
// rtl/mem_rst_pkg.sv - shared states, default cycle constants and counter sizing for mem_rst_seq
package mem_rst_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_PWRUP     = 3'd3,
    ST_INIT      = 3'd4,
    ST_READY     = 3'd5,
    ST_ERROR     = 3'd6
  } seq_state_e;

  localparam int SYNC_STAGES_DEF  = 2;
  localparam int LOCK_CYCLES_DEF  = 1024;
  localparam int RST_HOLD_DEF     = 16;
  localparam int PWRUP_CYCLES_DEF = 26600;
  localparam int INIT_TIMEOUT_DEF = 65535;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYCLES_DEF = max_of(max_of(LOCK_CYCLES_DEF, RST_HOLD_DEF),
                                         max_of(PWRUP_CYCLES_DEF, INIT_TIMEOUT_DEF));
  // One spare bit of headroom above the largest load value.
  localparam int CNT_W_DEF = $clog2(MAX_CYCLES_DEF) + 1;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchroniser with asynchronous active-low clear
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mem_rst_seq.sv
// rtl/mem_rst_seq.sv - lock qualification, domain reset release, power-up wait and init handshake
module mem_rst_seq
  import mem_rst_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int LOCK_CYCLES  = LOCK_CYCLES_DEF,
  parameter int RST_HOLD     = RST_HOLD_DEF,
  parameter int PWRUP_CYCLES = PWRUP_CYCLES_DEF,
  parameter int INIT_TIMEOUT = INIT_TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       clk133,
  input  logic       rst_n,
  input  logic       dcm_lock,
  input  logic       init_done,
  output logic       rst133,
  output logic       init_start,
  output logic       mem_ready,
  output logic       init_err,
  output logic [2:0] seq_state
);

  localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(INIT_TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst133_q, rst133_d;
  logic             init_start_q, init_start_d;
  logic             mem_ready_q, mem_ready_d;
  logic             init_err_q, init_err_d;
  logic             lock_s;
  logic [CNT_W-1:0] cnt_dec;
  logic             cnt_zero;
  logic             lock_lost;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clk133),
    .rst_ni (rst_n),
    .d_i    (dcm_lock),
    .q_o    (lock_s)
  );

  assign cnt_dec   = cnt_q - CNT_W'(1);
  assign cnt_zero  = (cnt_q == '0);
  assign lock_lost = !lock_s &&
                     (state_q inside {ST_HOLD, ST_PWRUP, ST_INIT, ST_READY, ST_ERROR});

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rst133_d     = rst133_q;
    init_start_d = 1'b0;
    mem_ready_d  = mem_ready_q;
    init_err_d   = init_err_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        rst133_d    = 1'b1;
        mem_ready_d = 1'b0;
        if (!lock_s) begin
          cnt_d = LOCK_LOAD;
        end else if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d  = ST_PWRUP;
          cnt_d    = PWRUP_LOAD;
          rst133_d = 1'b0;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_PWRUP: begin
        if (cnt_zero) begin
          state_d      = ST_INIT;
          cnt_d        = INIT_LOAD;
          init_start_d = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_INIT: begin
        // A done arriving on the timeout cycle still counts as success.
        if (init_done) begin
          state_d     = ST_READY;
          mem_ready_d = 1'b1;
        end else if (cnt_zero) begin
          state_d    = ST_ERROR;
          init_err_d = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_READY, ST_ERROR: begin
      end
      default: begin
        state_d     = ST_WAIT_LOCK;
        cnt_d       = LOCK_LOAD;
        rst133_d    = 1'b1;
        mem_ready_d = 1'b0;
      end
    endcase

    // Lock loss overrides any progress made this cycle; init_err stays sticky.
    if (lock_lost) begin
      state_d      = ST_WAIT_LOCK;
      cnt_d        = LOCK_LOAD;
      rst133_d     = 1'b1;
      mem_ready_d  = 1'b0;
      init_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk133 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      rst133_q     <= 1'b1;
      init_start_q <= 1'b0;
      mem_ready_q  <= 1'b0;
      init_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst133_q     <= rst133_d;
      init_start_q <= init_start_d;
      mem_ready_q  <= mem_ready_d;
      init_err_q   <= init_err_d;
    end
  end

  assign rst133     = rst133_q;
  assign init_start = init_start_q;
  assign mem_ready  = mem_ready_q;
  assign init_err   = init_err_q;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_mem_rst_seq.sv
// tb/tb_mem_rst_seq.sv - scoreboard bench for mem_rst_seq output transitions
module tb_mem_rst_seq;
  import mem_rst_pkg::*;

  logic       clk133    = 1'b0;
  logic       rst_n     = 1'b1;
  logic       dcm_lock  = 1'b0;
  logic       init_done = 1'b0;
  logic       rst133, init_start, mem_ready, init_err;
  logic [2:0] seq_state;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // {rst133, init_start, mem_ready, init_err, seq_state}
  typedef struct {
    int         c;
    logic [6:0] o;
  } ev_t;

  ev_t        exp_q[$];
  logic [6:0] cur;

  always #5 clk133 = ~clk133;
  always @(posedge clk133) cyc <= cyc + 1;

  mem_rst_seq #(
    .SYNC_STAGES  (2),
    .LOCK_CYCLES  (8),
    .RST_HOLD     (4),
    .PWRUP_CYCLES (20),
    .INIT_TIMEOUT (50),
    .CNT_W        (17)
  ) dut (
    .clk133     (clk133),
    .rst_n      (rst_n),
    .dcm_lock   (dcm_lock),
    .init_done  (init_done),
    .rst133     (rst133),
    .init_start (init_start),
    .mem_ready  (mem_ready),
    .init_err   (init_err),
    .seq_state  (seq_state)
  );

  assign cur = {rst133, init_start, mem_ready, init_err, seq_state};

  // Monitor: every change of the output vector must match the next expected event.
  initial begin
    logic [6:0] prev;
    ev_t        e;
    prev = 7'b1000000;
    forever begin
      @(negedge clk133);
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got=%b", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.o || cyc != e.c) begin
            errors++;
            $display("FAIL event got cyc=%0d out=%b required cyc=%0d out=%b", cyc, cur, e.c, e.o);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic push(input int c, input logic r, input logic s, input logic m,
                      input logic e, input logic [2:0] st);
    ev_t ev;
    ev.c = c;
    ev.o = {r, s, m, e, st};
    exp_q.push_back(ev);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk133);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Expected transitions of a lock-qualified bring-up starting from lock edge t.
  task automatic push_bringup(input int t, input logic e);
    push(t + 10, 1'b1, 1'b0, 1'b0, e, ST_HOLD);
    push(t + 14, 1'b0, 1'b0, 1'b0, e, ST_PWRUP);
    push(t + 34, 1'b0, 1'b1, 1'b0, e, ST_INIT);
    push(t + 35, 1'b0, 1'b0, 1'b0, e, ST_INIT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, t3, t4, t5, t6;
    #2 rst_n = 1'b0;
    step(3);
    chk("rst_rst133", 3'(rst133), 3'd1);
    chk("rst_init_start", 3'(init_start), 3'd0);
    chk("rst_mem_ready", 3'(mem_ready), 3'd0);
    chk("rst_init_err", 3'(init_err), 3'd0);
    chk("rst_state", seq_state, 3'd0);

    // Clean bring-up and init handshake.
    push(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, ST_WAIT_LOCK);
    rst_n = 1'b1;
    step(3);
    t0 = cyc;
    dcm_lock = 1'b1;
    push_bringup(t0, 1'b0);
    wait_until(t0 + 44);
    init_done = 1'b1;
    push(t0 + 45, 1'b0, 1'b0, 1'b1, 1'b0, ST_READY);
    wait_until(t0 + 47);
    init_done = 1'b0;

    // Lock loss in READY.
    wait_until(t0 + 50);
    t1 = cyc;
    dcm_lock = 1'b0;
    push(t1 + 3, 1'b1, 1'b0, 1'b0, 1'b0, ST_WAIT_LOCK);

    // Glitchy re-lock, then init timeout.
    wait_until(t1 + 6);
    t2 = cyc;
    dcm_lock = 1'b1;
    wait_until(t2 + 5);
    dcm_lock = 1'b0;
    wait_until(t2 + 6);
    dcm_lock = 1'b1;
    push_bringup(t2 + 6, 1'b0);
    push(t2 + 90, 1'b0, 1'b0, 1'b0, 1'b1, ST_ERROR);

    // Lock loss in ERROR keeps init_err, then re-lock.
    wait_until(t2 + 92);
    t3 = cyc;
    dcm_lock = 1'b0;
    push(t3 + 3, 1'b1, 1'b0, 1'b0, 1'b1, ST_WAIT_LOCK);
    wait_until(t3 + 6);
    t4 = cyc;
    dcm_lock = 1'b1;
    push(t4 + 10, 1'b1, 1'b0, 1'b0, 1'b1, ST_HOLD);
    push(t4 + 14, 1'b0, 1'b0, 1'b0, 1'b1, ST_PWRUP);

    // Async reset mid-PWRUP.
    wait_until(t4 + 20);
    t5 = cyc;
    push(t5, 1'b1, 1'b0, 1'b0, 1'b0, ST_RESET);
    rst_n = 1'b0;
    #1;
    chk("async_rst133", 3'(rst133), 3'd1);
    chk("async_mem_ready", 3'(mem_ready), 3'd0);
    chk("async_init_err", 3'(init_err), 3'd0);
    chk("async_state", seq_state, 3'd0);
    step(2);
    t6 = cyc;
    push(t6 + 1, 1'b1, 1'b0, 1'b0, 1'b0, ST_WAIT_LOCK);
    rst_n = 1'b1;
    push_bringup(t6, 1'b0);

    // init_done on the same cycle the INIT counter expires.
    wait_until(t6 + 83);
    init_done = 1'b1;
    push(t6 + 84, 1'b0, 1'b0, 1'b1, 1'b0, ST_READY);
    wait_until(t6 + 86);
    init_done = 1'b0;
    wait_until(t6 + 95);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rst_seq.md
Name: mem_rst_seq

Overview:
- Reset and power-up sequencer for the 133 MHz memory domain, running on clk133.
- Consumes dcm_lock, qualifies it as stable, then releases a synchronous domain reset.
- Enforces the 200 us DDR power-up wait, then hands off to the memory controller's init engine through a start/done handshake.
- Drops the domain back into reset whenever lock is lost.

Parameters:
- SYNC_STAGES, 2: flops in the dcm_lock synchroniser (min 2).
- LOCK_CYCLES, 1024: consecutive synchronised-lock cycles required before leaving WAIT_LOCK.
- RST_HOLD, 16: cycles rst133 stays asserted after lock qualifies.
- PWRUP_CYCLES, 26600: power-up wait (200 us at 133 MHz).
- INIT_TIMEOUT, 65535: maximum cycles from init_start to init_done.
- CNT_W, 17: shared down-counter width; must hold the largest of the above.

Ports:
- clk133, input, 1: memory-domain clock.
- rst_n, input, 1: asynchronous active-low reset.
- dcm_lock, input, 1: DCM locked, asynchronous to clk133.
- init_done, input, 1: level from the init engine; init sequence complete.
- rst133, output, 1: synchronous active-high reset to the memory domain.
- init_start, output, 1: single-cycle pulse requesting init.
- mem_ready, output, 1: memory usable.
- init_err, output, 1: sticky init timeout flag.
- seq_state, output, 3: current state encoding, for debug.

Behaviour:
- Reset values:
  - rst_n low asynchronously forces rst133=1, init_start=0, mem_ready=0, init_err=0.
  - It also forces state=RESET, counter=0, and clears the synchroniser.
- Synchroniser: dcm_lock passes through SYNC_STAGES flops to give lock_s. All decisions below use lock_s.
- RESET (0):
  - Next cycle go to WAIT_LOCK and load counter with LOCK_CYCLES-1.
- WAIT_LOCK (1):
  - rst133=1.
  - lock_s=0: reload counter to LOCK_CYCLES-1.
  - lock_s=1: decrement counter. At 0 with lock_s=1, go to HOLD and load RST_HOLD-1.
- HOLD (2):
  - rst133=1; decrement counter.
  - At 0, deassert rst133 on the transition to PWRUP and load PWRUP_CYCLES-1.
- PWRUP (3):
  - rst133=0; decrement counter.
  - At 0, go to INIT, pulse init_start for exactly one cycle (the first INIT cycle), and load INIT_TIMEOUT-1.
- INIT (4):
  - Decrement counter.
  - init_done=1: go to READY. mem_ready=1 from the next cycle.
  - Counter reaches 0 with init_done=0: go to ERROR and set init_err.
  - init_done=1 on the same cycle the counter hits 0: done wins, go to READY.
- READY (5):
  - mem_ready=1, rst133=0. Stay until lock is lost.
- ERROR (6):
  - mem_ready=0, init_err=1. Stay until lock is lost or rst_n.
- Lock loss, from any state other than RESET and WAIT_LOCK:
  - lock_s=0 sends the FSM to WAIT_LOCK next cycle.
  - rst133=1, mem_ready=0, init_start=0 on that same next cycle. Counter reloads LOCK_CYCLES-1.
  - init_err is sticky and cleared only by rst_n.
- Latency:
  - rst133 release = SYNC_STAGES + LOCK_CYCLES + RST_HOLD cycles after dcm_lock rises, ±1 for synchroniser phase.
  - mem_ready = 1 cycle after init_done is sampled in INIT.
- Outputs are registered; no combinational path exists from input to output.
- init_done asserted outside INIT is ignored.
- Encoding 7 is unreachable and decodes to RESET.

Decomposition:
- Package mem_rst_pkg holds:
  - the state enum (RESET..ERROR, 3 bits);
  - the default cycle constants;
  - the CNT_W derivation as a clog2 of the maximum parameter.
- Sub-module sync_ff (parameter STAGES): generic multi-flop synchroniser with async active-low clear. It is instantiated once, for dcm_lock.
- The FSM and the single shared down-counter live in mem_rst_seq.

Test Plan:
- Clean bring-up (LOCK_CYCLES=8, RST_HOLD=4, PWRUP_CYCLES=20, INIT_TIMEOUT=50):
  - raise dcm_lock at t0 → rst133 falls at t0+2+8+4 (±1);
  - init_start pulses once 20 cycles later;
  - init_done asserted 10 cycles after that → mem_ready=1 next cycle.
- Glitchy lock: dcm_lock high 5 cycles, low 1, high again → counter restarts; rst133 held until 8 uninterrupted lock cycles plus hold.
- Init timeout: init_done never asserted → at INIT_TIMEOUT=50 cycles after init_start, state=6, init_err=1, mem_ready=0.
- Lock loss in READY: drop dcm_lock → within SYNC_STAGES+1 cycles rst133=1, mem_ready=0, state=1; re-lock repeats the full sequence with exactly one new init_start.
- Simultaneous events: init_done rises on the cycle the INIT counter hits 0 → READY, init_err stays 0.
- Async reset mid-PWRUP: rst_n pulsed low → all outputs at reset values immediately; sequence restarts from WAIT_LOCK after release.
